// File: rtl/fpu_lzc_pkg.sv
// Shared types and elaboration helpers for the pipelined leading/trailing
// zero/one counter.
package fpu_lzc_pkg;

    typedef enum logic [1:0] {
        LZ = 2'd0,
        TZ = 2'd1,
        LO = 2'd2,
        TO = 2'd3
    } lzc_mode_e;

    function automatic int lzc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Tree level whose node state is held in register 'stage' (stage 0 = leaves).
    function automatic int lzc_stage_level(input int stage, input int levels, input int stages);
        return (stage * levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/fpu_pipe_reg.sv
// One elastic valid/ready register slice; holds its beat until downstream takes it.
module fpu_pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          load;

    assign load = ~valid_q | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/fpu_lzc_pipe.sv
// Pipelined leading/trailing zero/one counter: preprocess, OR/select tree split
// across PIPE_STAGES elastic slices, final register holds cnt/empty/tag.
module fpu_lzc_pipe
    import fpu_lzc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 1,
    localparam int CNT_W      = lzc_cnt_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_i,
    input  logic [1:0]       mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int PADW   = 1 << LEVELS;
    localparam int IW     = LEVELS;

    // Slice layout: tag in the low bits, then node sel bits, then node indices
    // (node 0 is the MSB side). The last slice holds tag, cnt, empty instead.
    function automatic int stage_dw(input int s);
        if (s == PIPE_STAGES) begin
            return TAG_W + CNT_W + 1;
        end
        return TAG_W + (PADW >> lzc_stage_level(s, LEVELS, PIPE_STAGES)) * (1 + IW);
    endfunction

    function automatic int stage_off(input int s);
        int acc;
        acc = 0;
        for (int t = 0; t < s; t++) begin
            acc += stage_dw(t);
        end
        return acc;
    endfunction

    localparam int BUS_W = stage_off(PIPE_STAGES + 1);
    localparam int OFF_L = stage_off(PIPE_STAGES);

    logic [BUS_W-1:0]       bus;
    logic [PIPE_STAGES:0]   valid;
    logic [PIPE_STAGES:0]   ready;

    lzc_mode_e              mode;
    logic                   rev;
    logic                   inv;
    logic [WIDTH-1:0]       pre;
    logic [stage_dw(0)-1:0] lvl0;

    assign mode = lzc_mode_e'(mode_i);
    assign rev  = (mode == TZ) || (mode == TO);
    assign inv  = (mode == LO) || (mode == TO);

    // Everything reduces to "leading zeros of pre"; padding leaves sit below the LSB.
    always_comb begin
        pre  = '0;
        lvl0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pre[i] = (rev ? in_i[WIDTH-1-i] : in_i[i]) ^ inv;
        end
        lvl0[TAG_W-1:0] = tag_i;
        for (int j = 0; j < WIDTH; j++) begin
            lvl0[TAG_W+j] = pre[WIDTH-1-j];
        end
    end

    assign bus[0 +: stage_dw(0)] = lvl0;
    assign valid[0]              = in_valid_i;

    // Unrolled ready chain: a stage can load if any stage downstream has a hole.
    always_comb begin
        logic acc;
        acc                = out_ready_i;
        ready              = '0;
        ready[PIPE_STAGES] = acc;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            acc      = acc | ~valid[s+1];
            ready[s] = acc;
        end
    end

    for (genvar s = 1; s <= PIPE_STAGES; s++) begin : g_stage
        localparam int LA    = lzc_stage_level(s - 1, LEVELS, PIPE_STAGES);
        localparam int LB    = lzc_stage_level(s, LEVELS, PIPE_STAGES);
        localparam int NA    = PADW >> LA;
        localparam int NB    = PADW >> LB;
        localparam int OFF_A = stage_off(s - 1);
        localparam int OFF_B = stage_off(s);
        localparam int DW_B  = stage_dw(s);

        logic [NA-1:0] sel_w;
        logic [IW-1:0] idx_w [NA];
        logic [DW_B-1:0] nxt;

        // In-place reduction: node j of the next level overwrites slot j, which
        // is never a child still waiting to be read. Left (MSB) child wins ties.
        always_comb begin
            for (int j = 0; j < NA; j++) begin
                sel_w[j] = bus[OFF_A + TAG_W + j];
                idx_w[j] = bus[OFF_A + TAG_W + NA + j*IW +: IW];
            end
            for (int k = LA; k < LB; k++) begin
                for (int j = 0; j < (PADW >> (k + 1)); j++) begin
                    if (sel_w[2*j]) begin
                        idx_w[j] = idx_w[2*j];
                    end else begin
                        idx_w[j] = idx_w[2*j+1] | IW'(1 << k);
                    end
                    sel_w[j] = sel_w[2*j] | sel_w[2*j+1];
                end
            end
        end

        if (s == PIPE_STAGES) begin : g_last
            always_comb begin
                nxt                  = '0;
                nxt[TAG_W-1:0]       = bus[OFF_A +: TAG_W];
                nxt[TAG_W +: CNT_W]  = sel_w[0] ? CNT_W'(idx_w[0]) : CNT_W'(WIDTH);
                nxt[TAG_W + CNT_W]   = ~sel_w[0];
            end
        end else begin : g_mid
            always_comb begin
                nxt            = '0;
                nxt[TAG_W-1:0] = bus[OFF_A +: TAG_W];
                for (int j = 0; j < NB; j++) begin
                    nxt[TAG_W + j]             = sel_w[j];
                    nxt[TAG_W + NB + j*IW +: IW] = idx_w[j];
                end
            end
        end

        fpu_pipe_reg #(
            .DW(DW_B)
        ) u_reg (
            .clk       (clk_i),
            .rst       (rst_i),
            .in_valid  (valid[s-1]),
            .in_data   (nxt),
            .out_ready (ready[s]),
            .out_valid (valid[s]),
            .out_data  (bus[OFF_B +: DW_B])
        );
    end

    assign in_ready_o  = ready[0];
    assign out_valid_o = valid[PIPE_STAGES];
    assign tag_o       = bus[OFF_L +: TAG_W];
    assign cnt_o       = bus[OFF_L + TAG_W +: CNT_W];
    assign empty_o     = bus[OFF_L + TAG_W + CNT_W];

endmodule
